// File: rtl/dcpu16_fsrsp_if.sv
// dcpu16_fsrsp_if: fetch-side handshake bundle for the DCPU-16 core.
// fs_err exists only when DCPU16_FSRSP_ERR_EN is defined.
interface dcpu16_fsrsp_if;
  logic        fs_ena;
  logic [15:0] fs_adr;
  logic        fs_ack;
  logic [15:0] fs_dti;
`ifdef DCPU16_FSRSP_ERR_EN
  logic        fs_err;

  modport master (
    output fs_ena, fs_adr,
    input  fs_ack, fs_dti, fs_err
  );
  modport slave (
    input  fs_ena, fs_adr,
    output fs_ack, fs_dti, fs_err
  );
`else
  modport master (
    output fs_ena, fs_adr,
    input  fs_ack, fs_dti
  );
  modport slave (
    input  fs_ena, fs_adr,
    output fs_ack, fs_dti
  );
`endif
endinterface

// File: rtl/dcpu16_fsrsp.sv
// dcpu16_fsrsp: fetch responder with program RAM and wait states.
// Option DCPU16_FSRSP_ERR_EN: faults fetches above 2**AW words.
module dcpu16_fsrsp #(
  parameter int AW = 10,
  parameter int WS = 0
) (
  input  logic          clk,
  input  logic          rst,
  dcpu16_fsrsp_if.slave fs,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_adr,
  input  logic [15:0]   ld_dat
);
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  localparam logic [3:0] WS_L = 4'(WS);
`ifdef DCPU16_FSRSP_ERR_EN
  localparam int QW = 16;
`else
  localparam int QW = AW;
`endif

  state_t        state;
  logic [3:0]    cnt;
  logic [QW-1:0] adr_q;
  logic [15:0]   mem [2**AW];

  logic [QW-1:0] rd_adr;
  logic          rd_go;
`ifdef DCPU16_FSRSP_ERR_EN
  logic          rd_oor;
`endif

  // Read address and read strobe for the cycle that launches the ack.
  always_comb begin
    rd_adr = (state == IDLE) ? fs.fs_adr[QW-1:0] : adr_q;
    rd_go  = 1'b0;
    case (state)
      IDLE:    rd_go = fs.fs_ena && (WS == 0);
      WAIT:    rd_go = fs.fs_ena && (cnt == 4'd1);
      default: rd_go = 1'b0;
    endcase
`ifdef DCPU16_FSRSP_ERR_EN
    rd_oor = (rd_adr >> AW) != '0;
`endif
  end

  // Loader write port; RAM is never cleared by reset.
  always_ff @(posedge clk) begin
    if (ld_we)
      mem[ld_adr] <= ld_dat;
  end

  // Handshake FSM with registered ack/data/error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      adr_q     <= '0;
      fs.fs_ack <= 1'b0;
      fs.fs_dti <= 16'h0000;
`ifdef DCPU16_FSRSP_ERR_EN
      fs.fs_err <= 1'b0;
`endif
    end else begin
      fs.fs_ack <= rd_go;
`ifdef DCPU16_FSRSP_ERR_EN
      fs.fs_err <= rd_go && rd_oor;
      if (rd_go)
        fs.fs_dti <= rd_oor ? 16'h0000
                            : mem[rd_adr[AW-1:0]];
`else
      if (rd_go)
        fs.fs_dti <= mem[rd_adr[AW-1:0]];
`endif
      case (state)
        IDLE: begin
          if (fs.fs_ena) begin
            adr_q <= fs.fs_adr[QW-1:0];
            cnt   <= WS_L;
            state <= (WS == 0) ? ACK : WAIT;
          end
        end
        WAIT: begin
          if (!fs.fs_ena) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == 4'd1) begin
            state <= ACK;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcpu16_fsrsp.sv
// tb_dcpu16_fsrsp: directed checks of the fetch responder.
// Three instances cover WS=0, WS=3 and WS=4 on shared stimulus.
module tb_dcpu16_fsrsp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic [15:0] adr = 16'h0000;
  logic        ld_we = 1'b0;
  logic [9:0]  ld_adr = 10'd0;
  logic [15:0] ld_dat = 16'h0000;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dcpu16_fsrsp_if i0 ();
  dcpu16_fsrsp_if i3 ();
  dcpu16_fsrsp_if i4 ();

  assign i0.fs_ena = ena;
  assign i0.fs_adr = adr;
  assign i3.fs_ena = ena;
  assign i3.fs_adr = adr;
  assign i4.fs_ena = ena;
  assign i4.fs_adr = adr;

  dcpu16_fsrsp #(.AW(10), .WS(0)) u0 (
    .clk(clk), .rst(rst), .fs(i0),
    .ld_we(ld_we), .ld_adr(ld_adr), .ld_dat(ld_dat)
  );
  dcpu16_fsrsp #(.AW(10), .WS(3)) u3 (
    .clk(clk), .rst(rst), .fs(i3),
    .ld_we(ld_we), .ld_adr(ld_adr), .ld_dat(ld_dat)
  );
  dcpu16_fsrsp #(.AW(10), .WS(4)) u4 (
    .clk(clk), .rst(rst), .fs(i4),
    .ld_we(ld_we), .ld_adr(ld_adr), .ld_dat(ld_dat)
  );

  typedef struct packed {
    logic        we;
    logic [9:0]  la;
    logic [15:0] ld;
    logic        ena;
    logic [15:0] adr;
    logic        ack;
    logic [15:0] dti;
    logic        err;
  } vec_t;

  vec_t v [14];

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [9:0] a, input logic [15:0] d);
    ld_we  = 1'b1;
    ld_adr = a;
    ld_dat = d;
    step();
    ld_we = 1'b0;
  endtask

  task automatic do_reset();
    ena = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] oor_dti;
    logic        oor_err;
`ifdef DCPU16_FSRSP_ERR_EN
    oor_dti = 16'h0000;
    oor_err = 1'b1;
`else
    oor_dti = 16'h7C01;
    oor_err = 1'b0;
`endif
    v[0]  = '{1'b0, 10'd0, 16'h0, 1'b1, 16'h0005, 1'b1, 16'h7C01, 1'b0};
    v[1]  = '{1'b0, 10'd0, 16'h0, 1'b0, 16'h0005, 1'b0, 16'h7C01, 1'b0};
    v[2]  = '{1'b0, 10'd0, 16'h0, 1'b1, 16'h0000, 1'b1, 16'h1000, 1'b0};
    v[3]  = '{1'b0, 10'd0, 16'h0, 1'b1, 16'h0001, 1'b0, 16'h1000, 1'b0};
    v[4]  = '{1'b0, 10'd0, 16'h0, 1'b1, 16'h0001, 1'b1, 16'h2001, 1'b0};
    v[5]  = '{1'b0, 10'd0, 16'h0, 1'b1, 16'h0002, 1'b0, 16'h2001, 1'b0};
    v[6]  = '{1'b0, 10'd0, 16'h0, 1'b1, 16'h0002, 1'b1, 16'h3002, 1'b0};
    v[7]  = '{1'b0, 10'd0, 16'h0, 1'b0, 16'h0002, 1'b0, 16'h3002, 1'b0};
    v[8]  = '{1'b1, 10'd7, 16'h2222, 1'b1, 16'h0007, 1'b1, 16'h1111, 1'b0};
    v[9]  = '{1'b0, 10'd0, 16'h0, 1'b0, 16'h0007, 1'b0, 16'h1111, 1'b0};
    v[10] = '{1'b0, 10'd0, 16'h0, 1'b1, 16'h0007, 1'b1, 16'h2222, 1'b0};
    v[11] = '{1'b0, 10'd0, 16'h0, 1'b0, 16'h0007, 1'b0, 16'h2222, 1'b0};
    v[12] = '{1'b0, 10'd0, 16'h0, 1'b1, 16'h0405, 1'b1, oor_dti, oor_err};
    v[13] = '{1'b0, 10'd0, 16'h0, 1'b0, 16'h0405, 1'b0, oor_dti, 1'b0};

    // Fill RAM while held in reset, then two more reset cycles.
    rst = 1'b1;
    load(10'd5,  16'h7C01);
    load(10'd0,  16'h1000);
    load(10'd1,  16'h2001);
    load(10'd2,  16'h3002);
    load(10'd7,  16'h1111);
    load(10'h10, 16'hA861);
    step();
    step();
    chk("rst_ack0", 16'(i0.fs_ack), 16'h0);
    chk("rst_dti0", i0.fs_dti, 16'h0);
    chk("rst_ack3", 16'(i3.fs_ack), 16'h0);
    chk("rst_dti3", i3.fs_dti, 16'h0);
    chk("rst_ack4", 16'(i4.fs_ack), 16'h0);
    chk("rst_dti4", i4.fs_dti, 16'h0);
`ifdef DCPU16_FSRSP_ERR_EN
    chk("rst_err0", 16'(i0.fs_err), 16'h0);
`endif
    rst = 1'b0;

    // WS=0 table: single read, back-to-back, collision, out-of-range.
    for (int i = 0; i < 14; i++) begin
      ld_we  = v[i].we;
      ld_adr = v[i].la;
      ld_dat = v[i].ld;
      ena    = v[i].ena;
      adr    = v[i].adr;
      step();
      chk($sformatf("vec%0d_ack", i), 16'(i0.fs_ack), 16'(v[i].ack));
      chk($sformatf("vec%0d_dti", i), i0.fs_dti, v[i].dti);
`ifdef DCPU16_FSRSP_ERR_EN
      chk($sformatf("vec%0d_err", i), 16'(i0.fs_err), 16'(v[i].err));
`endif
    end
    ld_we = 1'b0;

    // WS=3: ack in cycle N+4, one cycle wide, data held.
    do_reset();
    ena = 1'b1;
    adr = 16'h0010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("ws3_ack%0d", i), 16'(i3.fs_ack), 16'(i == 3));
      chk($sformatf("ws3_dti%0d", i), i3.fs_dti,
          (i == 3) ? 16'hA861 : 16'h0000);
    end
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("ws3_post_ack%0d", i), 16'(i3.fs_ack), 16'h0);
      chk($sformatf("ws3_post_dti%0d", i), i3.fs_dti, 16'hA861);
    end

    // WS=4 abort after 2 cycles: no ack, then a clean new transfer.
    do_reset();
    ena = 1'b1;
    adr = 16'h0010;
    step();
    step();
    ena = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("abort_ack%0d", i), 16'(i4.fs_ack), 16'h0);
      chk($sformatf("abort_dti%0d", i), i4.fs_dti, 16'h0);
    end
    ena = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("reissue_ack%0d", i), 16'(i4.fs_ack), 16'(i == 4));
    end
    chk("reissue_dti", i4.fs_dti, 16'hA861);
    ena = 1'b0;
    step();

    // WS=4 reset mid-WAIT: transfer dropped, data cleared.
    ena = 1'b1;
    step();
    step();
    rst = 1'b1;
    ena = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("midrst_ack%0d", i), 16'(i4.fs_ack), 16'h0);
      chk($sformatf("midrst_dti%0d", i), i4.fs_dti, 16'h0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dcpu16_fsrsp.md
# dcpu16_fsrsp

Instruction-fetch bus responder for the DCPU-16 core. It answers the fetch-side handshake (`fs_ena` request, `fs_ack` completion, `fs_dti` read data) that the core's control unit consumes, sourcing instruction words from an internal synchronous program RAM. A programmable wait-state count models slower memories and exercises the core's pipe-stall path. A separate loader write port fills the RAM from a testbench or boot master.

## Interface
- `AW`, 10: RAM address width. Depth is 2**AW words of 16 bits.
- `WS`, 0: wait states inserted before `fs_ack`. Range 0..15.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `fs_ena`  in  1  fetch request strobe. Held high by the master until `fs_ack`.
- `fs_adr`  in  16  fetch word address. Stable while `fs_ena` is high.
- `fs_ack`  out  1  transfer complete; high for exactly one cycle per transfer.
- `fs_dti`  out  16  instruction word. Valid when `fs_ack`=1 and held until the next ack.
- `fs_err`  out  1  address fault. Present only with `DCPU16_FSRSP_ERR_EN`.
- `ld_we`  in  1  loader write enable.
- `ld_adr`  in  AW  loader word address.
- `ld_dat`  in  16  loader write data.

## Operation
- FSM states: IDLE, WAIT, ACK.
- **IDLE**
  - If `fs_ena`=1: latch `fs_adr` into `adr_q` and load the wait counter with `WS`.
  - Go to WAIT if `WS`>0, else issue the RAM read and go to ACK.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter reaches 1, issue the RAM read (address `adr_q`) and go to ACK.
- **ACK**
  - `fs_ack`=1 and `fs_dti`=RAM output. Unconditionally return to IDLE.
  - A request still high in the next cycle is a new transfer, sampled in IDLE.
- **Abort:** if `fs_ena` falls in WAIT, return to IDLE with no ack. `fs_dti` keeps its old value.
- **Address width:** RAM index is `adr_q[AW-1:0]`. Upper bits are handled per Configuration.
- **Loader port:** independent of the FSM and writes in any state.
  - A write to the address being read in the same cycle returns the old data (read-before-write).
  - Writes in earlier cycles are visible.
- **RAM contents:** undefined after power-up. Reset does not clear the RAM.
- **Reset (also mid-transfer):** state IDLE, counter 0, `adr_q`=0, `fs_ack`=0, `fs_dti`=16'h0000, `fs_err`=0. An in-flight transfer is dropped with no ack.

## Timing
- Request first sampled high at edge N: `fs_ack` is high in cycle N+1+WS.
- Minimum spacing of acks under continuous `fs_ena` is WS+2 cycles; WS=0 gives one ack every 2 cycles.
- This matches the core's two-phase fetch, where a stall is `fs_ena`=1 with `fs_ack`=0.
- `fs_ack`, `fs_dti` and `fs_err` are registered outputs; none is combinational from inputs.
- `fs_adr` changes while `fs_ena`=1 are ignored after IDLE sampling. The latched address is used.

## Configuration
- Macro `DCPU16_FSRSP_ERR_EN`, **defined:**
  - `fs_err` port exists.
  - If `adr_q[15:AW]` is nonzero, the transfer still completes with normal latency, but `fs_ack`=1, `fs_err`=1 and `fs_dti`=16'h0000.
  - `fs_err` is 0 in every other cycle.
- **Not defined:**
  - No `fs_err` port.
  - Upper address bits are ignored; the address wraps modulo 2**AW.

## Test plan
- **Reset:** WS=0; load mem[5]=16'h7C01 via the loader; assert `rst` for 2 cycles. Expect `fs_ack`=0 and `fs_dti`=0. Then `fs_ena`=1, `fs_adr`=5 at edge N → `fs_ack`=1 and `fs_dti`=16'h7C01 in cycle N+1 only.
- **Wait states:** WS=3, mem[0x10]=16'hA861. Request at edge N → ack in cycle N+4, exactly one cycle wide; `fs_dti` holds 16'hA861 afterwards.
- **Back-to-back:** WS=0, `fs_ena` held high with addresses 0,1,2 advanced on each ack. Expect acks in alternate cycles with data mem[0..2], and no double ack.
- **Abort and reset mid-transfer:** WS=4. Drop `fs_ena` after 2 cycles → no ack and state IDLE. Repeat, asserting `rst` mid-WAIT → no ack and `fs_dti`=0.
- **Loader collision:** WS=0, mem[7]=16'h1111. In the read cycle, the loader writes 16'h2222 to address 7 → ack returns 16'h1111. A following read returns 16'h2222.
- **Out-of-range address:** AW=10, `fs_adr`=16'h0405.
  - With `DCPU16_FSRSP_ERR_EN`: ack with `fs_err`=1 and `fs_dti`=0.
  - Without it: data is mem[5].
